neural_soc_isig_stream_ctrl: RTL
================================

Name:
neural_soc_isig_stream_ctrl

Overview:
- Avalon-MM slave sequencer that feeds input-signal words to the neural datapath.
- CPU pushes 32-bit words into a small FIFO, programs a burst length and sets enable.
- Block streams exactly LEN words on a valid/ready interface, marks the final word with last, then raises done/irq.
- Replaces direct CPU toggling of the hardware input port with flow-controlled bursts.

Parameters:
- DATA_W, 32, stream/data word width
- FIFO_DEPTH, 8, FIFO entries (power of 2, >=2)
- CNT_W, 16, burst length counter width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe (no side effects; decode uses address only)
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address, zero wait states
- irq  out  1  interrupt, level
- isig_data  out  DATA_W  stream data
- isig_valid  out  1  stream valid
- isig_last  out  1  final beat of burst
- isig_ready  in  1  datapath accept

Behaviour:
- Reset: reset_n, asynchronous, active-low; clock clk. All state cleared; FIFO empty; FSM IDLE; isig_valid=0, isig_last=0, isig_data=0, irq=0, every register field 0.
- Write = chipselect & ~write_n.
- Register map:
  - addr0 DATA: write pushes writedata into the FIFO; reads 0.
  - addr1 CTRL: bit0 enable, bit1 irq_en, bit2 flush (write-1 pulse, reads 0).
  - addr2 LEN: CNT_W bits, zero-extended on read. Writes ignored unless IDLE.
  - addr3 STATUS: bit0 busy (state!=IDLE), bit1 fifo_empty, bit2 fifo_full, bit3 done (W1C), bit4 ovf (W1C), [11:8] fifo level, [31:16] remaining beats to accept.
- FIFO:
  - Push when full with no pop in the same cycle: word dropped, ovf set.
  - Push and pop in the same cycle when full: both take effect; level unchanged.
  - Flush empties the FIFO in one cycle. It does not touch the output register. A push in the flush cycle is discarded.
- Output register:
  - Loads from the FIFO head when (~isig_valid | isig_ready) & FIFO not empty & state==RUN & issue_cnt!=0.
  - Each load decrements issue_cnt.
  - isig_last is registered with the data and equals (issue_cnt==1) at load time.
  - Once asserted, isig_valid, isig_data and isig_last are held stable until isig_ready is seen.
  - Back-to-back beats are sustained at 1 word/cycle.
  - Latency: FIFO non-empty in RUN -> isig_valid on the next clock.
- FSM:
  - IDLE -> RUN when enable=1 & LEN!=0. On entry, issue_cnt=LEN and remaining=LEN.
  - RUN: each accepted beat (valid & ready) decrements remaining.
    - Accepted beat with last=1 -> IDLE; set done.
    - enable cleared -> DRAIN.
  - DRAIN: no new loads.
    - Outstanding beat accepted, or none outstanding -> IDLE.
    - remaining cleared; done is not set.
    - If the accepted beat carried last, done is set.
  - enable=1 & LEN=0: stays IDLE.
  - enable left at 1 after done: a new burst starts on the next cycle.
- Starvation (FIFO empty in RUN): isig_valid deasserts after its outstanding beat is accepted; the burst resumes when data arrives. No timeout.
- irq = irq_en & (done | ovf), registered, so it asserts 1 cycle after the event.
- W1C of done or ovf in the same cycle as a new set event: the set wins.

Decomposition:
- Package neural_soc_isig_pkg holds:
  - register address constants (DATA/CTRL/LEN/STATUS)
  - CTRL/STATUS bit positions
  - FSM state enum (IDLE, RUN, DRAIN)
- One sub-module: neural_soc_isig_fifo. Synchronous FIFO with push/pop/flush, full/empty/level, and first-word-fall-through head output.

Test Plan:
- Push 0x11,0x22,0x33; LEN=3; CTRL=1; ready held 1 -> three consecutive beats 0x11,0x22,0x33; last only on 0x33; STATUS.done=1; busy=0.
- Same burst with ready toggling 1,0,0,1,... -> data/last stable while valid & ~ready; order preserved; done after the 3rd accept.
- Push 9 words with FIFO_DEPTH=8, no burst running -> level=8, full=1, ovf=1; irq=1 if irq_en; writing STATUS=0x10 clears ovf and irq.
- LEN=4 with only 2 words pushed -> 2 beats, then valid=0 with remaining=2; push 2 more -> beats 3-4 with last on the 4th.
- LEN=5, clear enable after 2 accepts with beat 3 pending and ready=0 -> beat 3 held; on ready it is accepted, then IDLE, done=0, remaining=0.
- Assert reset_n=0 mid-burst with valid high -> isig_valid=0 and FIFO empty immediately; all registers 0 after release.

Source files
------------

// File: rtl/neural_soc_isig_pkg.sv
// Shared definitions for the input-signal stream sequencer: register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package neural_soc_isig_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_LEN    = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_EMPTY_BIT  = 1;
    localparam int STAT_FULL_BIT   = 2;
    localparam int STAT_DONE_BIT   = 3;
    localparam int STAT_OVF_BIT    = 4;
    localparam int STAT_LEVEL_LSB  = 8;
    localparam int STAT_LEVEL_W    = 4;
    localparam int STAT_REMAIN_LSB = 16;
    localparam int STAT_REMAIN_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/neural_soc_isig_fifo.sv
// Small synchronous FIFO with first-word-fall-through head, single-cycle
// flush and a full-cycle push+pop that keeps the level unchanged.
module neural_soc_isig_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [DATA_W-1:0]        o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_level = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/neural_soc_isig_stream_ctrl.sv
// Avalon-MM programmed burst sequencer: CPU fills a FIFO, sets LEN and enable,
// and the block streams exactly LEN words on valid/ready with last, then done/irq.
module neural_soc_isig_stream_ctrl
    import neural_soc_isig_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic              read_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [DATA_W-1:0] isig_data,
    output logic              isig_valid,
    output logic              isig_last,
    input  logic              isig_ready
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_enable, r_irq_en, r_done, r_ovf, r_irq;
    logic              r_valid, r_last;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_len, r_issue_cnt, r_remaining;

    logic              w_wr, w_wr_data, w_wr_ctrl, w_wr_len, w_wr_status, w_flush;
    logic              w_enable_next, w_irq_en_next, w_done_next, w_ovf_next;
    logic              w_start, w_abort, w_done_set, w_ovf_set;
    logic              w_accept, w_load;
    logic [DATA_W-1:0] w_fifo_head;
    logic              w_fifo_empty, w_fifo_full;
    logic [LVL_W-1:0]  w_level;
    logic [31:0]       w_status;
    logic              w_unused;

    // Reads have no side effects, so the read strobe carries no information.
    assign w_unused = read_n;

    assign w_wr        = chipselect & ~write_n;
    assign w_wr_data   = w_wr & (address == ADDR_DATA);
    assign w_wr_ctrl   = w_wr & (address == ADDR_CTRL);
    assign w_wr_len    = w_wr & (address == ADDR_LEN);
    assign w_wr_status = w_wr & (address == ADDR_STATUS);
    assign w_flush     = w_wr_ctrl & writedata[CTRL_FLUSH_BIT];

    assign w_accept  = r_valid & isig_ready;
    assign w_load    = (~r_valid | isig_ready) & ~w_fifo_empty & (r_state == ST_RUN)
                     & (r_issue_cnt != '0) & ~w_flush;
    assign w_ovf_set = w_wr_data & w_fifo_full & ~w_load & ~w_flush;

    neural_soc_isig_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_wr_data),
        .i_push_data (DATA_W'(writedata)),
        .i_pop       (w_load),
        .i_flush     (w_flush),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_level     (w_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_abort      = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_enable && (r_len != '0)) begin
                    w_state_next = ST_RUN;
                    w_start      = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_accept && r_last) begin
                    w_state_next = ST_IDLE;
                    w_done_set   = 1'b1;
                end else if (!r_enable) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_accept || !r_valid) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                    w_done_set   = w_accept & r_last;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sticky flags: a set event in the same cycle as a W1C wins.
    always_comb begin
        w_enable_next = r_enable;
        w_irq_en_next = r_irq_en;
        if (w_wr_ctrl) begin
            w_enable_next = writedata[CTRL_ENABLE_BIT];
            w_irq_en_next = writedata[CTRL_IRQ_EN_BIT];
        end
        w_done_next = r_done;
        if (w_wr_status && writedata[STAT_DONE_BIT]) begin
            w_done_next = 1'b0;
        end
        if (w_done_set) begin
            w_done_next = 1'b1;
        end
        w_ovf_next = r_ovf;
        if (w_wr_status && writedata[STAT_OVF_BIT]) begin
            w_ovf_next = 1'b0;
        end
        if (w_ovf_set) begin
            w_ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable    <= 1'b0;
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
            r_irq       <= 1'b0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= '0;
        end else begin
            r_enable <= w_enable_next;
            r_irq_en <= w_irq_en_next;
            r_done   <= w_done_next;
            r_ovf    <= w_ovf_next;
            r_irq    <= w_irq_en_next & (w_done_next | w_ovf_next);

            if (w_wr_len && (r_state == ST_IDLE)) begin
                r_len <= writedata[CNT_W-1:0];
            end

            if (w_start) begin
                r_issue_cnt <= r_len;
                r_remaining <= r_len;
            end else if (w_abort) begin
                r_issue_cnt <= '0;
                r_remaining <= '0;
            end else begin
                if (w_load) begin
                    r_issue_cnt <= r_issue_cnt - CNT_ONE;
                end
                if (w_accept) begin
                    r_remaining <= r_remaining - CNT_ONE;
                end
            end

            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_fifo_head;
                r_last  <= (r_issue_cnt == CNT_ONE);
            end else if (w_accept) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status = '0;
        w_status[STAT_BUSY_BIT]  = (r_state != ST_IDLE);
        w_status[STAT_EMPTY_BIT] = w_fifo_empty;
        w_status[STAT_FULL_BIT]  = w_fifo_full;
        w_status[STAT_DONE_BIT]  = r_done;
        w_status[STAT_OVF_BIT]   = r_ovf;
        w_status[STAT_LEVEL_LSB +: STAT_LEVEL_W]   = STAT_LEVEL_W'(w_level);
        w_status[STAT_REMAIN_LSB +: STAT_REMAIN_W] = STAT_REMAIN_W'(r_remaining);
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL: begin
                readdata[CTRL_ENABLE_BIT] = r_enable;
                readdata[CTRL_IRQ_EN_BIT] = r_irq_en;
            end
            ADDR_LEN:    readdata = 32'(r_len);
            ADDR_STATUS: readdata = w_status;
            default:     readdata = '0;
        endcase
    end

    assign irq        = r_irq;
    assign isig_data  = r_data;
    assign isig_valid = r_valid;
    assign isig_last  = r_last;

endmodule
